button_conditioner: RTL and testbench

//  Upstream stage for the combination lock. Turns raw, bouncing, asynchronous push-button levels

---
 rtl/button_conditioner_if.sv | 23 ++
 rtl/button_conditioner.sv | 146 ++++++++++++++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Push-button conditioner bus: raw pad levels in, debounced levels and press pulses out.
interface button_conditioner_if #(
    parameter int unsigned N_BUTTONS = 4
);
    logic [N_BUTTONS-1:0] buttons_raw;
    logic [N_BUTTONS-1:0] buttons;
    logic [N_BUTTONS-1:0] stable;
    logic                 held;

    modport master (
        output buttons_raw,
        input  buttons,
        input  stable,
        input  held
    );

    modport slave (
        input  buttons_raw,
        output buttons,
        output stable,
        output held
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces raw buttons, then emits one single-cycle one-hot pulse per press.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN (auto-repeat of held non-cancel keys).
module button_conditioner #(
    parameter int unsigned N_BUTTONS       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    button_conditioner_if.slave bus
);

    localparam int unsigned DB_LAST = DEBOUNCE_CYCLES - 1;

    // Reject configurations the counters cannot represent.
    if ((DEBOUNCE_CYCLES < 2) || (REPEAT_CYCLES < 2) || (CNT_W > 32) ||
        ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES))) begin : g_bad_cfg
        $error("button_conditioner: invalid DEBOUNCE_CYCLES/CNT_W/REPEAT_CYCLES");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_e;

    logic [N_BUTTONS-1:0] sync1_q;
    logic [N_BUTTONS-1:0] sync2_q;
    logic [N_BUTTONS-1:0] stable_q;
    logic [N_BUTTONS-1:0] stable_d;
    logic [N_BUTTONS-1:0] rise_q;
    logic [N_BUTTONS-1:0] press_onehot;
    logic [N_BUTTONS-1:0] buttons_q;
    logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_d [N_BUTTONS];
    logic                 held_q;
    state_e               state_q;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    logic [RPT_W-1:0]     rpt_q;
    logic [N_BUTTONS-1:0] last_q;
`endif

    // Per-button debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DB_LAST)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Synchroniser, debounced level and registered press events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            for (int unsigned i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= bus.buttons_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= stable_d & ~stable_q;
            for (int unsigned i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Highest-index press wins so cancel beats any digit in a chord.
    always_comb begin
        press_onehot = '0;
        for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            if (rise_q[i]) begin
                press_onehot    = '0;
                press_onehot[i] = 1'b1;
            end
        end
    end

    // Lockout FSM: one pulse on entry to HELD, nothing more until every key is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            buttons_q <= '0;
            held_q    <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_q     <= '0;
            last_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|rise_q) begin
                        buttons_q <= press_onehot;
                        held_q    <= 1'b1;
                        state_q   <= ST_HELD;
`ifdef BUTTON_AUTO_REPEAT_EN
                        rpt_q     <= '0;
                        last_q    <= press_onehot;
`endif
                    end else begin
                        buttons_q <= '0;
                    end
                end
                ST_HELD: begin
                    buttons_q <= '0;
                    if (stable_q == '0) begin
                        held_q  <= 1'b0;
                        state_q <= ST_IDLE;
`ifdef BUTTON_AUTO_REPEAT_EN
                    end else if (rpt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
                        rpt_q <= '0;
                        if (!last_q[N_BUTTONS-1]) begin
                            buttons_q <= last_q;
                        end
                    end else begin
                        rpt_q <= rpt_q + RPT_W'(1);
`endif
                    end
                end
                default: begin
                    buttons_q <= '0;
                    held_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.buttons = buttons_q;
    assign bus.stable  = stable_q;
    assign bus.held    = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=10.
module tb_button_conditioner;

    localparam int unsigned NB = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned RC = 10;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    button_conditioner_if #(.N_BUTTONS(NB)) bus ();

    button_conditioner #(
        .N_BUTTONS      (NB),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW),
        .REPEAT_CYCLES  (RC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int        n_chk     = 0;
    int        n_pass    = 0;
    int        pulse_cnt = 0;
    int        base;
    logic [3:0] seen     = '0;
    logic [3:0] prev     = '0;
    bit        mon_en    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] b, input logic [3:0] s, input logic h);
        chk({tag, ".buttons"}, 32'(bus.buttons), 32'(b));
        chk({tag, ".stable"},  32'(bus.stable),  32'(s));
        chk({tag, ".held"},    32'(bus.held),    32'(h));
    endtask

    // Continuous output properties plus pulse bookkeeping.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot0", 32'($onehot0(bus.buttons)), 32'd1);
            chk("no_back_to_back", 32'((bus.buttons != 4'd0) && (prev != 4'd0)), 32'd0);
            if (bus.buttons != 4'd0) pulse_cnt++;
            seen = seen | bus.buttons;
            prev = bus.buttons;
        end
    end

    initial begin
        int         run [NB];
        logic [3:0] r;

        reset = 1'b0;
        bus.buttons_raw = '0;
        #2 reset = 1'b1;
        tick(3);
        chk_out("reset", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick(3);

        // 1: single press, debounce boundary, release without pulse
        base = pulse_cnt;
        bus.buttons_raw = 4'b0001;
        tick(5);
        chk_out("t1.pre_stable", 4'b0000, 4'b0000, 1'b0);
        tick(1);
        chk_out("t1.stable_rise", 4'b0000, 4'b0001, 1'b0);
        tick(1);
        chk_out("t1.pulse", 4'b0001, 4'b0001, 1'b1);
        tick(1);
        chk_out("t1.after_pulse", 4'b0000, 4'b0001, 1'b1);
        tick(12);
        bus.buttons_raw = 4'b0000;
        tick(5);
        chk_out("t1.rel_pre", 4'b0000, 4'b0001, 1'b1);
        tick(1);
        chk_out("t1.rel_stable", 4'b0000, 4'b0000, 1'b1);
        tick(1);
        chk_out("t1.rel_idle", 4'b0000, 4'b0000, 1'b0);
        chk("t1.pulses", 32'(pulse_cnt - base), 32'(1 + REP));
        tick(3);

        // 2: bouncing press yields exactly one pulse
        base = pulse_cnt;
        for (int k = 0; k < 4; k++) begin
            bus.buttons_raw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(1);
            chk("t2.bounce_stable", 32'(bus.stable), 32'd0);
        end
        bus.buttons_raw = 4'b0010;
        tick(6);
        chk_out("t2.stable_rise", 4'b0000, 4'b0010, 1'b0);
        tick(1);
        chk_out("t2.pulse", 4'b0010, 4'b0010, 1'b1);
        bus.buttons_raw = 4'b0000;
        tick(8);
        chk_out("t2.idle", 4'b0000, 4'b0000, 1'b0);
        chk("t2.pulses", 32'(pulse_cnt - base), 32'd1);
        tick(3);

        // 3: chord priority, partial releases, new press while held
        base = pulse_cnt;
        seen = '0;
        bus.buttons_raw = 4'b1001;
        tick(7);
        chk_out("t3.chord_pulse", 4'b1000, 4'b1001, 1'b1);
        tick(1);
        bus.buttons_raw = 4'b0001;
        tick(7);
        chk_out("t3.rel_cancel", 4'b0000, 4'b0001, 1'b1);
        bus.buttons_raw = 4'b0101;
        tick(8);
        chk_out("t3.press_in_held", 4'b0000, 4'b0101, 1'b1);
        chk("t3.pulses_mid", 32'(pulse_cnt - base), 32'd1);
        bus.buttons_raw = 4'b0000;
        tick(8);
        chk_out("t3.all_released", 4'b0000, 4'b0000, 1'b0);
        bus.buttons_raw = 4'b0100;
        tick(7);
        chk_out("t3.new_pulse", 4'b0100, 4'b0100, 1'b1);
        bus.buttons_raw = 4'b0000;
        tick(8);
        chk("t3.pulses", 32'(pulse_cnt - base), 32'd2);
        chk("t3.seen_bits", 32'(seen), 32'b1100);
        tick(3);

        // 4: reset mid-debounce with the key held through reset release
        base = pulse_cnt;
        bus.buttons_raw = 4'b0010;
        tick(3);
        reset = 1'b1;
        #1;
        chk_out("t4.reset_async", 4'b0000, 4'b0000, 1'b0);
        tick(3);
        chk_out("t4.in_reset", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        tick(6);
        chk_out("t4.stable_rise", 4'b0000, 4'b0010, 1'b0);
        tick(1);
        chk_out("t4.pulse", 4'b0010, 4'b0010, 1'b1);
        bus.buttons_raw = 4'b0000;
        tick(8);
        chk("t4.pulses", 32'(pulse_cnt - base), 32'd1);
        chk("t4.held", 32'(bus.held), 32'd0);
        tick(3);

        // 5: long hold (repeats only when the feature is built), cancel never repeats
        base = pulse_cnt;
        bus.buttons_raw = 4'b0001;
        tick(7);
        chk("t5.first", 32'(bus.buttons), 32'b0001);
        for (int k = 0; k < 3; k++) begin
            tick(9);
            chk("t5.gap", 32'(bus.buttons), 32'd0);
            tick(1);
            chk("t5.repeat", 32'(bus.buttons), (REP == 1) ? 32'b0001 : 32'd0);
        end
        tick(3);
        bus.buttons_raw = 4'b0000;
        tick(8);
        chk("t5.pulses_digit", 32'(pulse_cnt - base), 32'(1 + 3 * REP));
        base = pulse_cnt;
        bus.buttons_raw = 4'b1000;
        tick(7);
        chk("t5.cancel_pulse", 32'(bus.buttons), 32'b1000);
        tick(33);
        bus.buttons_raw = 4'b0000;
        tick(8);
        chk("t5.pulses_cancel", 32'(pulse_cnt - base), 32'd1);
        tick(3);

        // 6: short-run noise never produces a debounced level or a pulse
        base = pulse_cnt;
        r = '0;
        for (int b = 0; b < int'(NB); b++) run[b] = 0;
        for (int c = 0; c < 1000; c++) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (run[b] == 0) begin
                    r[b] = ~r[b];
                    run[b] = int'($urandom_range(1, 3));
                end
                run[b]--;
            end
            bus.buttons_raw = r;
            tick(1);
            chk("t6.stable", 32'(bus.stable), 32'd0);
        end
        bus.buttons_raw = 4'b0000;
        tick(6);
        chk("t6.pulses", 32'(pulse_cnt - base), 32'd0);
        chk("t6.held", 32'(bus.held), 32'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
